// File: rtl/seg_bus_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg_bus_if
//  Brief    : Bus-side port bundle for the 7-segment scan driver.
//  Revision : 1.0  initial release
// ============================================================================
interface seg_bus_if;
    logic        cs_n;
    logic        rw;
    logic [31:0] mosi;
    logic [31:0] miso;

    modport master (output cs_n, output rw, output mosi, input  miso);
    modport slave  (input  cs_n, input  rw, input  mosi, output miso);
endinterface
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_driver
//  Brief    : Bus-mapped 8-digit hex common-anode display scanner with
//             anti-ghost blank cycle and optional leading-zero blanking.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_driver #(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic       sck,
    input  logic       rst,
    seg_bus_if.slave   bus,
    output logic [7:0] seg_sel,
    output logic [7:0] seg_code
);
    localparam int              C_CW      = $clog2(SCAN_DIV);
    localparam logic [C_CW-1:0] C_DIV_MAX = C_CW'(SCAN_DIV - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    logic [31:0]     r_data;
    logic [C_CW-1:0] r_div_cnt;
    logic [2:0]      r_idx;

    state_t          w_state;
    logic [3:0]      w_nibble;
    logic            w_lz_blank;
    logic [7:0]      w_code;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    assign bus.miso = r_data;

    // The first cycle of every slot is dark so the previous digit's segments
    // never bleed into the newly selected anode.
    assign w_state    = (r_div_cnt == '0) ? ST_BLANK : ST_DRIVE;
    assign w_nibble   = r_data[{r_idx, 2'b00} +: 4];
    assign w_lz_blank = BLANK_LZ && (r_idx != 3'd0) &&
                        ((r_data >> {r_idx, 2'b00}) == 32'd0);
    assign w_code     = w_lz_blank ? 8'hFF : hex_to_seg(w_nibble);

    always_ff @(posedge sck) begin
        if (rst) begin
            r_data    <= 32'd0;
            r_div_cnt <= '0;
            r_idx     <= 3'd0;
            seg_sel   <= 8'hFF;
            seg_code  <= 8'hFF;
        end else begin
            if (!bus.cs_n && bus.rw) begin
                r_data <= bus.mosi;
            end

            if (r_div_cnt == C_DIV_MAX) begin
                r_div_cnt <= '0;
                r_idx     <= r_idx + 3'd1;
            end else begin
                r_div_cnt <= r_div_cnt + C_CW'(1);
            end

            case (w_state)
                ST_BLANK: begin
                    seg_sel  <= 8'hFF;
                    seg_code <= 8'hFF;
                end
                default: begin
                    seg_sel  <= ~(8'b1 << r_idx);
                    seg_code <= w_code;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_driver
//  Brief    : Self-checking bench: two scanners (plain and leading-zero
//             blanking) against a cycle-count based display model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_driver;
    localparam int SD = 4;

    logic        sck = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1;
    logic        rw = 1'b0;
    logic [31:0] mosi = 32'd0;
    logic [7:0]  sel0, code0, sel1, code1;

    seg_bus_if bus0 ();
    seg_bus_if bus1 ();
    assign bus0.cs_n = cs_n;
    assign bus0.rw   = rw;
    assign bus0.mosi = mosi;
    assign bus1.cs_n = cs_n;
    assign bus1.rw   = rw;
    assign bus1.mosi = mosi;

    seg_scan_driver #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut0 (
        .sck(sck), .rst(rst), .bus(bus0), .seg_sel(sel0), .seg_code(code0));
    seg_scan_driver #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut1 (
        .sck(sck), .rst(rst), .bus(bus1), .seg_sel(sel1), .seg_code(code1));

    always #5 sck = ~sck;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the n-th clock edge after reset release sits at prescaler phase
    // n mod SD inside slot n / SD; phase 0 is dark, other phases light digit.
    int          m_n = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_data = 32'd0;
    logic [7:0]  m_sel = 8'hFF, m_code0 = 8'hFF, m_code1 = 8'hFF;

    always @(posedge sck) begin
        if (rst) begin
            m_valid = 1'b1;
            m_n     = 0;
            m_data  = 32'd0;
            m_sel   = 8'hFF;
            m_code0 = 8'hFF;
            m_code1 = 8'hFF;
        end else begin
            int ph, dig;
            ph  = m_n % SD;
            dig = (m_n / SD) % 8;
            if (ph == 0) begin
                m_sel   = 8'hFF;
                m_code0 = 8'hFF;
                m_code1 = 8'hFF;
            end else begin
                m_sel   = ~(8'd1 << dig);
                m_code0 = hex_tab[(m_data >> (4 * dig)) & 32'hF];
                m_code1 = (dig > 0 && (m_data >> (4 * dig)) == 32'd0) ? 8'hFF : m_code0;
            end
            if (!cs_n && rw) m_data = mosi;
            m_n++;
        end
    end

    always @(negedge sck) begin
        if (m_valid) begin
            chk("sel",      {24'd0, sel0},  {24'd0, m_sel});
            chk("code",     {24'd0, code0}, {24'd0, m_code0});
            chk("sel_lz",   {24'd0, sel1},  {24'd0, m_sel});
            chk("code_lz",  {24'd0, code1}, {24'd0, m_code1});
            chk("miso",     bus0.miso, m_data);
            chk("miso_lz",  bus1.miso, m_data);
            chk("one_low",  32'($countones(~sel0) <= 1), 32'd1);
        end
    end

    task automatic tick();
        @(posedge sck);
        #2;
    endtask

    task automatic write(input logic [31:0] d);
        cs_n = 1'b0; rw = 1'b1; mosi = d;
        tick();
        cs_n = 1'b1; rw = 1'b0;
    endtask

    // Advance until sel0 first becomes s (start of that digit's lit phase).
    task automatic wait_sel(input logic [7:0] s, input string name);
        int k;
        logic [7:0] prev;
        k = 0;
        prev = sel0;
        while (!(sel0 == s && prev != s) && k < 200) begin
            prev = sel0;
            tick();
            k++;
        end
        if (k >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: timeout waiting for sel %h, got %h", name, s, sel0);
        end
    endtask

    task automatic capture(output logic [7:0] seen0 [8], output logic [7:0] seen1 [8],
                           output int blanks);
        blanks = 0;
        for (int i = 0; i < 8; i++) begin
            seen0[i] = 8'h00;
            seen1[i] = 8'h00;
        end
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c < 32 && sel0 == 8'hFF) blanks++;
            for (int i = 0; i < 8; i++) begin
                if (sel0 == ~(8'd1 << i)) seen0[i] = code0;
                if (sel1 == ~(8'd1 << i)) seen1[i] = code1;
            end
        end
    endtask

    logic [7:0] s0 [8];
    logic [7:0] s1 [8];
    int         nb;
    logic [7:0] exp_hex [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
    logic [7:0] exp_lz  [8] = '{8'hC0, 8'hA4, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    initial begin
        // Reset held three cycles
        tick(); tick(); tick();
        chk("rst_sel",  {24'd0, sel0}, 32'hFF);
        chk("rst_code", {24'd0, code0}, 32'hFF);
        chk("rst_miso", bus0.miso, 32'd0);
        rst = 1'b0;
        tick();
        chk("first_blank", {24'd0, sel0}, 32'hFF);
        tick();
        chk("first_sel",  {24'd0, sel0}, 32'hFE);
        chk("first_code", {24'd0, code0}, 32'hC0);

        // Full hex pattern across all eight digits
        write(32'h89ABCDEF);
        capture(s0, s1, nb);
        for (int i = 0; i < 8; i++) chk($sformatf("hex_dig%0d", i), {24'd0, s0[i]}, {24'd0, exp_hex[i]});
        chk("blank_cycles", nb, 32'd8);

        // Ungated accesses must not change the register
        cs_n = 1'b1; rw = 1'b1; mosi = 32'h1234_5678;
        tick();
        chk("no_cs_write", bus0.miso, 32'h89ABCDEF);
        cs_n = 1'b0; rw = 1'b0; mosi = 32'h0BAD_F00D;
        tick();
        chk("read_only", bus0.miso, 32'h89ABCDEF);
        cs_n = 1'b1;

        // Same-cycle read sees old value, next cycle sees new one
        cs_n = 1'b0; rw = 1'b1; mosi = 32'h0000_0120;
        #1;
        chk("same_cycle_old", bus0.miso, 32'h89ABCDEF);
        tick();
        cs_n = 1'b1; rw = 1'b0;
        chk("next_cycle_new", bus0.miso, 32'h0000_0120);
        capture(s0, s1, nb);
        for (int i = 0; i < 8; i++) chk($sformatf("lz_dig%0d", i), {24'd0, s1[i]}, {24'd0, exp_lz[i]});
        chk("nolz_dig3", {24'd0, s0[3]}, 32'hC0);

        // Mid-slot write into digit 0
        wait_sel(8'hFE, "wait_d0");
        chk("mid_old", {24'd0, code0}, 32'hC0);
        write(32'h0000_0005);
        chk("mid_still_old", {24'd0, code0}, 32'hC0);
        chk("mid_still_sel", {24'd0, sel0}, 32'hFE);
        tick();
        chk("mid_new", {24'd0, code0}, 32'h92);
        tick();
        chk("mid_slot_end", {24'd0, sel0}, 32'hFF);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 79) == 0);
            cs_n = 1'($urandom_range(0, 1));
            rw   = 1'($urandom_range(0, 1));
            mosi = $urandom >> $urandom_range(0, 31);
            tick();
        end
        rst = 1'b0; cs_n = 1'b1; rw = 1'b0;
        write(32'hFEDC_BA98);

        // Reset in the middle of digit 5
        wait_sel(8'hDF, "wait_d5");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("d5rst_sel",  {24'd0, sel0}, 32'hFF);
        chk("d5rst_code", {24'd0, code0}, 32'hFF);
        chk("d5rst_miso", bus0.miso, 32'd0);
        tick();
        chk("d5rst_blank", {24'd0, sel0}, 32'hFF);
        tick();
        chk("d5rst_sel0",  {24'd0, sel0}, 32'hFE);
        chk("d5rst_code0", {24'd0, code0}, 32'hC0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
